// File: rtl/keypad_scan_encoder_pkg.sv
// keypad_pkg: shared FSM state type and sizing helpers for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_REL} kp_state_e;
  function automatic int code_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic logic frame_end(input int row, input int rows);
    return row == rows - 1;
  endfunction
endpackage

// File: rtl/keypad_scan_encoder_if.sv
// keypad_scan_encoder_if: key code valid/ready handshake toward the register bank
interface keypad_scan_encoder_if #(parameter int CODE_W = 4);
  logic [CODE_W-1:0] key_code;
  logic key_valid;
  logic key_ready;
  modport master(output key_code, key_valid, input key_ready);
  modport slave(input key_code, key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_encoder_debounce_fsm.sv
// keypad_debounce_fsm: frame-rate press/release debouncer, emits once per accepted press
module keypad_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int CODE_W   = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              frame_end,
  input  logic              hit,
  input  logic [CODE_W-1:0] code,
  output logic              emit,
  output logic              held
);
  localparam logic [3:0] DB = 4'(DEBOUNCE);
  kp_state_e state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [CODE_W-1:0] cur, cur_n;
  logic same;
  assign same = hit && code == cur;
  assign held = state == PRESSED;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      cur   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cur   <= cur_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cur_n   = cur;
    emit    = 1'b0;
    if (clear) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (frame_end)
      case (state)
        IDLE: if (hit) begin
          cur_n   = code;
          cnt_n   = 4'd1;
          state_n = (DEBOUNCE == 1) ? PRESSED : DB_PRESS;
          emit    = DEBOUNCE == 1;
        end
        DB_PRESS: if (!hit) state_n = IDLE;
          else if (!same) begin
            cur_n = code;
            cnt_n = 4'd1;
          end else begin
            cnt_n   = cnt + 4'd1;
            state_n = (cnt_n == DB) ? PRESSED : DB_PRESS;
            emit    = cnt_n == DB;
          end
        PRESSED: if (!same) begin
          cnt_n   = 4'd1;
          state_n = (DEBOUNCE == 1) ? IDLE : DB_REL;
        end
        DB_REL: if (same) state_n = PRESSED;
          else begin
            cnt_n   = cnt + 4'd1;
            state_n = (cnt_n == DB) ? IDLE : DB_REL;
          end
        default: state_n = IDLE;
      endcase
  end
endmodule

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: matrix keypad row scanner, frame debouncer and 1-entry key code buffer
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [COLS-1:0]      col_in,
  output logic [ROWS-1:0]      row_out,
  output logic                 key_held,
  output logic                 overflow,
  input  logic                 overflow_clr,
  keypad_scan_encoder_if.master kbus
);
  localparam int CODE_W = code_width(ROWS * COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(ROWS);
  logic [COLS-1:0] s1, s2;
  logic [DW-1:0] dwell;
  logic [RW-1:0] row;
  logic run, cand_hit, last, fend, row_hit, f_hit, emit, valid_q;
  logic [CODE_W-1:0] cand_code, row_code, f_code, code_q;
  // run keeps the rows undriven while reset is asserted even if en is high
  assign row_out = (en && run) ? ROWS'(1) << row : '0;
  assign last    = en && run && dwell == DW'(SCAN_DIV - 1);
  assign fend    = last && frame_end(int'(row), ROWS);
  assign f_hit   = cand_hit || (last && row_hit);
  assign f_code  = cand_hit ? cand_code : row_code;
  assign kbus.key_code  = code_q;
  assign kbus.key_valid = valid_q;
  // rows are scanned in ascending order, so the first hit of a frame is the lowest index
  always_comb begin
    row_hit  = |s2;
    row_code = '0;
    for (int c = COLS - 1; c >= 0; c--)
      if (s2[c]) row_code = CODE_W'(int'(row) * COLS + c);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      run       <= 1'b0;
      dwell     <= '0;
      row       <= '0;
      cand_hit  <= 1'b0;
      cand_code <= '0;
    end else begin
      s1  <= col_in;
      s2  <= s1;
      run <= 1'b1;
      if (!en) begin
        dwell    <= '0;
        row      <= '0;
        cand_hit <= 1'b0;
      end else if (run) begin
        dwell <= last ? '0 : dwell + 1'b1;
        if (last) row <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
        if (fend) cand_hit <= 1'b0;
        else if (last && row_hit && !cand_hit) begin
          cand_hit  <= 1'b1;
          cand_code <= row_code;
        end
      end
    end
  keypad_debounce_fsm #(.CODE_W(CODE_W), .DEBOUNCE(DEBOUNCE)) u_fsm (
    .clk(clk), .rst_n(rst_n), .clear(!en), .frame_end(fend),
    .hit(f_hit), .code(f_code), .emit(emit), .held(key_held)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      code_q   <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (emit && (!valid_q || kbus.key_ready)) begin
        code_q  <= f_code;
        valid_q <= 1'b1;
      end else if (kbus.key_ready) valid_q <= 1'b0;
      overflow <= (emit && valid_q && !kbus.key_ready) || (overflow && !overflow_clr);
    end
endmodule
